// File: rtl/pipe_stage_pkg.sv
// Shared pipeline definitions: stage occupancy encoding reused by every
// two-entry skid stage between decode and execute.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Encoding doubles as the held-payload count.
  function automatic logic [1:0] occ_of(stage_state_e st);
    return logic'(st == ST_BUSY) ? 2'd1 : (st == ST_FULL) ? 2'd2 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Decode->execute handshake bundle: upstream channel, downstream channel,
// branch-flush kill and occupancy status.
interface pipe_stage_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage.sv
// Two-entry skid pipeline register: main register feeds downstream, skid
// register absorbs one payload so in_ready can be a flop.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_stage_if.slave bus
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_BUSY;
          main_d  = bus.in_data;
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            skid_d  = bus.in_data;
          end else if (in_fire && out_fire) begin
            main_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (out_fire) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Ready is precomputed from next state so out_ready never reaches in_ready
    // combinationally.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.occupancy = occ_of(state_q);
  assign bus.out_data  = (ZERO_BUBBLE && !out_valid) ? '0 : main_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed vector table, streaming,
// async reset corners and a randomized queue-model scoreboard.
module tb_pipe_stage;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_stage_if #(.DATA_W(DW)) bus ();

  pipe_stage #(.DATA_W(DW), .ZERO_BUBBLE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [DW-1:0] od,
                         input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, DW'(bus.out_valid), DW'(ov));
    chk({tag, ".out_data"},  bus.out_data,       od);
    chk({tag, ".in_ready"},  DW'(bus.in_ready),  DW'(ir));
    chk({tag, ".occupancy"}, DW'(bus.occupancy), DW'(occ));
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
    logic [1:0]    occ;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy, logic fl,
                              logic ov, logic [DW-1:0] od, logic ir, logic [1:0] occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  vec_t vecs[16];
  logic [DW-1:0] q[$];

  initial begin
    vecs[0]  = mk(1, 'h11, 1, 0,  1, 'h11, 1, 1);
    vecs[1]  = mk(0, 'h00, 1, 0,  0, 'h00, 1, 0);
    vecs[2]  = mk(1, 'hA1, 0, 0,  1, 'hA1, 1, 1);
    vecs[3]  = mk(1, 'hA2, 0, 0,  1, 'hA1, 0, 2);
    vecs[4]  = mk(1, 'hA3, 0, 0,  1, 'hA1, 0, 2);
    vecs[5]  = mk(0, 'h00, 1, 0,  1, 'hA2, 1, 1);
    vecs[6]  = mk(0, 'h00, 1, 0,  0, 'h00, 1, 0);
    vecs[7]  = mk(1, 'hB1, 0, 0,  1, 'hB1, 1, 1);
    vecs[8]  = mk(1, 'hB2, 0, 0,  1, 'hB1, 0, 2);
    vecs[9]  = mk(1, 'hB3, 0, 1,  0, 'h00, 1, 0);
    vecs[10] = mk(0, 'h00, 1, 0,  0, 'h00, 1, 0);
    vecs[11] = mk(1, 'hC1, 1, 0,  1, 'hC1, 1, 1);
    vecs[12] = mk(1, 'hC2, 1, 0,  1, 'hC2, 1, 1);
    vecs[13] = mk(0, 'h00, 0, 1,  0, 'h00, 1, 0);
    vecs[14] = mk(1, 'hD1, 1, 0,  1, 'hD1, 1, 1);
    vecs[15] = mk(1, 'hD2, 1, 1,  0, 'h00, 1, 0);

    // Reset state
    rst_n = 1'b0;
    drive(0, '0, 0, 0);
    #1 chk_out("rst_async", 0, '0, 0, 0);
    repeat (3) @(posedge clk);
    #2 chk_out("rst_held", 0, '0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("rst_release", 0, '0, 1, 0);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].ir, vecs[i].occ);
    end

    // Streaming: one delivery per cycle, ready never drops
    for (int i = 0; i < 100; i++) begin
      drive(1, DW'(i), 1, 0);
      @(posedge clk); #1;
      chk($sformatf("stream%0d.data", i), bus.out_data, DW'(i));
      chk($sformatf("stream%0d.ready", i), DW'(bus.in_ready), DW'(1));
      chk($sformatf("stream%0d.valid", i), DW'(bus.out_valid), DW'(1));
    end
    drive(0, '0, 1, 0);
    @(posedge clk); #1;
    chk_out("stream_drain", 0, '0, 1, 0);

    // Reset asserted between edges while FULL
    drive(1, 'hE1, 0, 0);
    @(posedge clk); #1;
    drive(1, 'hE2, 0, 0);
    @(posedge clk); #1;
    chk_out("pre_rst_full", 1, 'hE1, 0, 2);
    drive(0, '0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("mid_rst", 0, '0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("post_rst1", 0, '0, 1, 0);
    @(posedge clk); #1;
    chk_out("post_rst2", 0, '0, 1, 0);

    // Randomized run against a capacity-2 FIFO model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic          iv, ordy, fl, ir_a;
      logic [DW-1:0] d;
      bit            in_fire, out_fire;
      chk("rnd.out_valid", DW'(bus.out_valid), DW'(q.size() > 0));
      chk("rnd.out_data",  bus.out_data, (q.size() > 0) ? q[0] : '0);
      chk("rnd.in_ready",  DW'(bus.in_ready), DW'(q.size() < 2));
      chk("rnd.occupancy", DW'(bus.occupancy), DW'(q.size()));
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 31) == 0);
      d    = {$urandom, $urandom};
      drive(iv, d, ordy, fl);
      #1 ir_a = bus.in_ready;
      bus.out_ready = ~ordy;
      #1 chk("rnd.ready_no_comb", DW'(bus.in_ready), DW'(ir_a));
      bus.out_ready = ordy;
      in_fire  = iv && (q.size() < 2);
      out_fire = ordy && (q.size() > 0);
      if (fl) q.delete();
      else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire)  q.push_back(d);
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits; legal range 1..256.
REQ-002 Parameter ZERO_BUBBLE, default 1; when 1, out_data SHALL be all-zero whenever out_valid=0.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream (decode side) payload valid.
REQ-006 in_ready  output  1  stage can accept a payload this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 out_valid  output  1  payload presented to downstream (execute side).
REQ-009 out_ready  input  1  downstream accepts payload this cycle.
REQ-010 out_data  output  DATA_W  downstream payload.
REQ-011 flush  input  1  synchronous kill of all held payloads (branch mispredict).
REQ-012 occupancy  output  2  number of held payloads, 0..2.

Function
REQ-013 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both evaluated on the same edge.
REQ-014 Storage SHALL be a main register (drives out_data) plus one skid register; states EMPTY (0 held), BUSY (1), FULL (2).
REQ-015 in_ready SHALL be a registered output, 1 in EMPTY and BUSY, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-016 out_valid SHALL be 1 in BUSY and FULL, 0 in EMPTY; out_data SHALL come from main register only (no combinational path from in_data).
REQ-017 EMPTY: in_fire -> BUSY, main <= in_data; otherwise stay.
REQ-018 BUSY: in_fire & !out_fire -> FULL, skid <= in_data; in_fire & out_fire -> BUSY, main <= in_data; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-019 FULL: out_fire -> BUSY, main <= skid; otherwise hold; in_fire impossible (in_ready=0).
REQ-020 Latency: payload accepted at edge N SHALL be visible on out_data after edge N (one cycle) when stage was EMPTY or BUSY-with-out_fire.
REQ-021 Ordering: payloads SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-022 flush=1: next state EMPTY, any concurrent in_fire payload discarded; an out_fire in the same cycle counts as delivered; flush has priority over every transition.
REQ-023 After flush, in_ready SHALL be 1 from the following cycle.
REQ-024 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL, registered.
REQ-025 Held payloads SHALL not change while out_valid=1 and out_ready=0 (stall).

Reset
REQ-026 On rst_n=0, asynchronously: state EMPTY, out_valid=0, in_ready=0, occupancy=0, main and skid registers zero, out_data zero.
REQ-027 in_ready SHALL rise on the first rising clk edge after rst_n deasserts; no transfer occurs during reset.
REQ-028 Reset asserted mid-operation SHALL discard all held payloads without a downstream transfer.

Structure
REQ-029 State encoding (EMPTY/BUSY/FULL) SHALL live in the shared pipeline package as a typedef, reused by other stage registers.
REQ-030 Control FSM and datapath SHALL be one module; no sub-module required. Decode/execute field packing into DATA_W is done by the instantiating level.

Verification
REQ-031 Reset release, in_valid=1, in_data=0x11, out_ready=1 -> out_valid=1, out_data=0x11 one cycle after acceptance; occupancy=1.
REQ-032 out_ready=0, push 0xA1, 0xA2 -> occupancy=2, in_ready=0, out_data=0xA1 held; raise out_ready -> 0xA1 then 0xA2 delivered in order, in_ready back to 1.
REQ-033 Streaming 100 payloads 0..99 with out_ready=1, in_valid=1 -> one delivery per cycle, in order, in_ready never drops.
REQ-034 FULL (0xB1, 0xB2), flush=1 with in_valid=1, in_data=0xB3 -> next cycle occupancy=0, out_valid=0, out_data=0 (ZERO_BUBBLE=1); 0xB3 never delivered.
REQ-035 Random in_valid/out_ready (50%) for 10,000 cycles, DATA_W=64 -> scoreboard: no loss, no duplication, order preserved, in_ready never combinationally follows out_ready.
REQ-036 rst_n=0 asserted with occupancy=2 between edges -> outputs zero immediately (asynchronously); after release no stale payload appears.
